// File: rtl/lcd_result_feeder.sv
// Double-buffered FP result feeder for the LCD instruction word generator.
// Optional sample counter shown at ptr 29..31: define LCD_FEEDER_SAMPLE_COUNT_EN.
module lcd_result_feeder #(
  parameter int RESTART_CYCLES = 4,
  parameter int CHAR_FIRST     = 4,
  parameter int CHAR_LAST      = 43
) (
  input  logic        oneUSClk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_p,
  input  logic [3:0]  in_flags,
  input  logic [5:0]  lcd_cmd_ptr,
  output logic [3:0]  nib_out,
  output logic        lcd_restart,
  output logic        frame_busy
);
  localparam logic [5:0] PTR_FIRST = 6'(CHAR_FIRST);
  localparam logic [5:0] PTR_LAST  = 6'(CHAR_LAST);
  localparam logic [5:0] PTR_DONE  = 6'(CHAR_LAST + 1);
  localparam logic [3:0] RST_LOAD  = 4'(RESTART_CYCLES);

  logic [31:0] pend_a_q, pend_b_q, pend_p_q;
  logic [31:0] disp_a_q, disp_b_q, disp_p_q;
  logic [3:0]  pend_f_q, disp_f_q;
  logic        pend_full_q, pend_full_d;
  logic        in_ready_q;
  logic [3:0]  rst_cnt_q, rst_cnt_d;
  logic        restart_q;
  logic [3:0]  nib_q, nib_d, cnt_nib;
  logic        accept, commit;
  logic [5:0]  off;
  logic [4:0]  word_idx;

  assign frame_busy = (lcd_cmd_ptr >= PTR_FIRST) && (lcd_cmd_ptr <= PTR_LAST);
  assign accept     = in_valid && in_ready_q;
  // Display buffer only swaps between frames and never during a restart pulse.
  assign commit     = pend_full_q && !frame_busy && (rst_cnt_q == 4'd0);
  assign off        = lcd_cmd_ptr - PTR_FIRST;
  assign word_idx   = {3'd7 - off[2:0], 2'b00};

`ifdef LCD_FEEDER_SAMPLE_COUNT_EN
  logic [11:0] cnt_q;

  always_comb begin
    case (off[1:0])
      2'd1:    cnt_nib = cnt_q[11:8];
      2'd2:    cnt_nib = cnt_q[7:4];
      default: cnt_nib = cnt_q[3:0];
    endcase
  end

  always_ff @(posedge oneUSClk or posedge reset) begin
    if (reset)       cnt_q <= '0;
    else if (commit) cnt_q <= cnt_q + 12'd1;
  end
`else
  assign cnt_nib = 4'h0;
`endif

  always_comb begin
    pend_full_d = pend_full_q;
    if (accept)      pend_full_d = 1'b1;
    else if (commit) pend_full_d = 1'b0;

    rst_cnt_d = (rst_cnt_q != 4'd0) ? rst_cnt_q - 4'd1 : 4'd0;
    if (commit && (lcd_cmd_ptr == PTR_DONE)) rst_cnt_d = RST_LOAD;

    nib_d = 4'h0;
    if (frame_busy) begin
      case (off[5:3])
        3'd0:    nib_d = disp_a_q[word_idx +: 4];
        3'd1:    nib_d = disp_b_q[word_idx +: 4];
        3'd2:    nib_d = disp_p_q[word_idx +: 4];
        3'd3:    nib_d = (off[2:0] == 3'd0) ? disp_f_q : (off[2] ? 4'h0 : cnt_nib);
        default: nib_d = 4'h0;
      endcase
    end
  end

  always_ff @(posedge oneUSClk or posedge reset) begin
    if (reset) begin
      pend_full_q <= 1'b0;
      in_ready_q  <= 1'b1;
      rst_cnt_q   <= 4'd0;
      restart_q   <= 1'b0;
      nib_q       <= 4'h0;
      pend_a_q    <= '0;
      pend_b_q    <= '0;
      pend_p_q    <= '0;
      pend_f_q    <= '0;
      disp_a_q    <= '0;
      disp_b_q    <= '0;
      disp_p_q    <= '0;
      disp_f_q    <= '0;
    end else begin
      pend_full_q <= pend_full_d;
      in_ready_q  <= !pend_full_d;
      rst_cnt_q   <= rst_cnt_d;
      restart_q   <= (rst_cnt_d != 4'd0);
      nib_q       <= nib_d;
      if (accept) begin
        pend_a_q <= in_a;
        pend_b_q <= in_b;
        pend_p_q <= in_p;
        pend_f_q <= in_flags;
      end
      if (commit) begin
        disp_a_q <= pend_a_q;
        disp_b_q <= pend_b_q;
        disp_p_q <= pend_p_q;
        disp_f_q <= pend_f_q;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign lcd_restart = restart_q;
  assign nib_out     = nib_q;
endmodule

// File: doc/lcd_result_feeder.md
Name: lcd_result_feeder

Overview:
- Upstream stage of the LCD instruction word generator.
- Accepts FP multiplier results (operand A, operand B, product, status flags) over a valid/ready handshake.
- Double-buffers each result so a character frame on the LCD never mixes two results.
- Returns the hex nibble for whichever character position the generator's pointer selects.
- Requests a generator restart when a new result arrives after a frame has completed, so the display refreshes.

Parameters:
- RESTART_CYCLES, 4, number of cycles lcd_restart is held high per refresh request (legal range 1..15).
- CHAR_FIRST, 4, first pointer value that is a character write.
- CHAR_LAST, 43, last pointer value that is a character write. Pointer value 44 means the frame is done.

Ports:
- oneUSClk  in  1  system clock (1 MHz tick domain).
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  a result is offered this cycle.
- in_ready  out  1  the pending buffer is free.
- in_a  in  32  operand A (IEEE-754 single).
- in_b  in  32  operand B.
- in_p  in  32  product.
- in_flags  in  4  {overflow, underflow, nan, zero}.
- lcd_cmd_ptr  in  6  command/character pointer from the generator.
- nib_out  out  4  hex nibble for the generator's data_in.
- lcd_restart  out  1  synchronous restart request; top level ORs it into the generator's reset.
- frame_busy  out  1  high while the pointer is inside CHAR_FIRST..CHAR_LAST.

Behaviour:
- Reset values: nib_out=0, in_ready=1, lcd_restart=0, frame_busy=0, pending buffer empty, display buffer all zero, sample_cnt=0, restart counter=0.
- Handshake:
  - in_ready = NOT pend_full, driven from a register.
  - A result is accepted when in_valid AND in_ready: {a,b,p,flags} latch into the pending buffer and pend_full is set.
  - When in_ready=0, in_valid is ignored. No data is dropped; the producer holds.
- Window: frame_busy = (CHAR_FIRST <= lcd_cmd_ptr <= CHAR_LAST), combinational.
- Commit:
  - Condition: pend_full AND NOT frame_busy AND restart counter == 0.
  - On commit, the pending buffer copies to the display buffer, pend_full clears, and sample_cnt increments (12-bit, wraps 4095->0).
  - Accept and commit are never in the same cycle, because accept requires pend_full=0.
  - The earliest commit is the cycle after accept.
- Restart:
  - If a commit occurs while lcd_cmd_ptr == 44, the restart counter loads RESTART_CYCLES on that edge.
  - lcd_restart = (counter != 0), registered. The counter decrements each cycle to 0.
  - A commit while ptr < CHAR_FIRST (generator still initialising) does NOT restart.
  - While the counter is non-zero, further commits stall.
- Nibble map: nib_out is registered, with 1-cycle latency from lcd_cmd_ptr.
  - ptr 4..11: display A, nibbles [31:28] down to [3:0].
  - ptr 12..19: display B, same ordering.
  - ptr 20..27: display P, same ordering.
  - ptr 28: display flags.
  - ptr 29..31: sample_cnt[11:8], [7:4], [3:0].
  - ptr 32..43: 0.
  - ptr 0..3, 44..63: 0.
  - The generator's 2-cycle pointer delay plus this 1 cycle fits inside its 2.6 ms character delay.
- Reset mid-operation: everything returns to reset values immediately, including pending and display data. An in-flight restart pulse is cut.
- The display buffer changes only on commit, so it is stable for the whole window 4..43.

Optional Feature:
- Macro LCD_FEEDER_SAMPLE_COUNT_EN.
- Defined: sample_cnt is implemented and shown at ptr 29..31.
- Undefined: the counter is not built and ptr 29..31 return 0.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then hold ptr=0. Offer A=3F800000, B=40000000, P=40000000, flags=0 -> accepted in 1 cycle; commit next cycle; lcd_restart stays 0; in_ready returns to 1. Sweep ptr 4..27 -> nib_out sequence 3,F,8,0,0,0,0,0 / 4,0,0,0,0,0,0,0 / 4,0,0,0,0,0,0,0, each 1 cycle after the ptr change.
- ptr=10 (busy). Offer result R1 -> accepted, no commit, in_ready=0. A second offer R2 is held off. ptr moves to 44 -> commit R1 that cycle; lcd_restart high exactly 4 cycles starting the next edge; R2 is then accepted; R2 commits only after restart ends.
- ptr=44 after two commits (macro defined) -> ptr 29..31 read 0,0,2. Same run with the macro undefined -> 0,0,0.
- Flags=4'b1010 committed -> ptr 28 gives A; ptr 35 gives 0; ptr 60 gives 0.
- Assert reset while lcd_restart is high and pend_full=1 -> next cycle lcd_restart=0, in_ready=1, nib_out=0 for all ptr values.
- 4096 back-to-back commits at ptr=0 (macro defined) -> sample_cnt wraps, ptr 29..31 read 0,0,0.
